// File: rtl/noc_pkg.sv
// Flit type codes and FSM state encoding shared by the router output stage.
package noc_pkg;
  localparam int TYPEW = 2;

  localparam logic [TYPEW-1:0] TYPE_NONE = 2'd0;
  localparam logic [TYPEW-1:0] TYPE_HEAD = 2'd1;
  localparam logic [TYPEW-1:0] TYPE_DATA = 2'd2;
  localparam logic [TYPEW-1:0] TYPE_TAIL = 2'd3;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic is_head(input logic [TYPEW-1:0] t);
    return t == TYPE_HEAD;
  endfunction

  function automatic logic is_tail(input logic [TYPEW-1:0] t);
    return t == TYPE_TAIL;
  endfunction
endpackage

// File: rtl/pkt_mux_arb_if.sv
// Flit input ports, output link and status of the N:1 packet mux.
interface pkt_mux_arb_if #(
  parameter int NPORT = 4,
  parameter int FLITW = 66,
  parameter int VCHW  = 2,
  parameter int CNTW  = 16
);
  logic [NPORT*FLITW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic [NPORT-1:0]       sel;
  logic [FLITW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic [NPORT-1:0]       grant;
  logic                   err_stray;
  logic [CNTW-1:0]        pkt_cnt;

  modport slave (
    input  idata, ivalid, ivch, sel, oready,
    output iready, odata, ovalid, ovch, grant, err_stray, pkt_cnt
  );

  modport master (
    output idata, ivalid, ivch, sel, oready,
    input  iready, odata, ovalid, ovch, grant, err_stray, pkt_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, modulo NPORT.
module rr_arbiter #(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] gnt
);
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      for (int k = 0; k < NPORT; k++) begin
        if (!found && req[k] && k == (int'(ptr) + i) % NPORT) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pkt_mux_arb.sv
// N:1 wormhole packet mux: grant locked HEAD..TAIL, registered output with valid/ready.
module pkt_mux_arb #(
  parameter int NPORT = 4,
  parameter int PAYW  = 64,
  parameter int TYPEW = noc_pkg::TYPEW,
  parameter int VCHW  = 2,
  parameter int MODE  = 0,
  parameter int CNTW  = 16
) (
  input  logic         clk,
  input  logic         rst,
  pkt_mux_arb_if.slave bus
);
  import noc_pkg::*;

  localparam int FLITW = TYPEW + PAYW;
  localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t           state, state_nx;
  logic [NPORT-1:0] owner;
  logic [PW-1:0]    rr_ptr, owner_idx;
  logic [NPORT-1:0] req, tail_vec, stray, rr_gnt, win, iready_c, acc_vec;
  logic             can_load, sel_ok, acc, acc_tail;
  logic [FLITW-1:0] acc_flit;
  logic [VCHW-1:0]  acc_vch;

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    logic [TYPEW-1:0] pt;
    assign pt          = bus.idata[k*FLITW+PAYW +: TYPEW];
    assign req[k]      = bus.ivalid[k] & is_head(pt);
    assign tail_vec[k] = is_tail(pt);
    // non-HEAD traffic on a port that does not own the output is drained
    assign stray[k]    = bus.ivalid[k] & ~is_head(pt) & ~owner[k];
  end

  rr_arbiter #(.NPORT(NPORT), .PW(PW)) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign sel_ok   = $onehot(bus.sel) && |(bus.sel & req);
  assign win      = (MODE == 1) ? (sel_ok ? bus.sel : '0) : rr_gnt;
  assign can_load = ~bus.ovalid | bus.oready;
  assign acc      = |acc_vec;

  always_comb begin
    state_nx = state;
    iready_c = stray;
    acc_vec  = '0;
    acc_tail = 1'b0;
    case (state)
      IDLE: begin
        iready_c = stray | (win & {NPORT{can_load}});
        acc_vec  = win & bus.ivalid & {NPORT{can_load}};
        if (|acc_vec) state_nx = LOCKED;
      end
      LOCKED: begin
        iready_c = stray | (owner & {NPORT{can_load}});
        acc_vec  = owner & bus.ivalid & {NPORT{can_load}};
        acc_tail = |(acc_vec & tail_vec);
        if (acc_tail) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    acc_flit  = '0;
    acc_vch   = '0;
    owner_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (acc_vec[k]) begin
        acc_flit = bus.idata[k*FLITW +: FLITW];
        acc_vch  = bus.ivch[k*VCHW +: VCHW];
      end
      if (owner[k]) owner_idx = PW'(k);
    end
  end

  assign bus.iready = iready_c;
  assign bus.grant  = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner         <= '0;
      rr_ptr        <= '0;
      bus.pkt_cnt   <= '0;
      bus.err_stray <= 1'b0;
    end else begin
      bus.err_stray <= |stray;
      if (state == IDLE && acc) begin
        owner <= acc_vec;
      end else if (acc_tail) begin
        owner       <= '0;
        rr_ptr      <= (owner_idx == PW'(NPORT-1)) ? '0 : owner_idx + 1'b1;
        bus.pkt_cnt <= bus.pkt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.odata  <= '0;
      bus.ovch   <= '0;
      bus.ovalid <= 1'b0;
    end else if (acc) begin
      bus.odata  <= acc_flit;
      bus.ovch   <= acc_vch;
      bus.ovalid <= 1'b1;
    end else if (bus.oready) begin
      bus.ovalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pkt_mux_arb.sv
// Directed bench: round-robin instance and external-select instance of pkt_mux_arb.
module tb_pkt_mux_arb;
  import noc_pkg::*;

  localparam int NPORT = 4;
  localparam int PAYW  = 16;
  localparam int FLITW = TYPEW + PAYW;
  localparam int VCHW  = 2;
  localparam int CNTW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  pkt_mux_arb_if #(.NPORT(NPORT), .FLITW(FLITW), .VCHW(VCHW), .CNTW(CNTW)) b0 ();
  pkt_mux_arb_if #(.NPORT(NPORT), .FLITW(FLITW), .VCHW(VCHW), .CNTW(CNTW)) b1 ();

  logic [FLITW-1:0] pd [NPORT];
  logic             pv [NPORT];
  logic [FLITW-1:0] qd [NPORT];
  logic             qv [NPORT];
  logic             ordy0 = 1'b1;
  logic [NPORT-1:0] sel1 = '0;

  always_comb begin
    b0.idata  = '0;
    b0.ivalid = '0;
    b1.idata  = '0;
    b1.ivalid = '0;
    for (int k = 0; k < NPORT; k++) begin
      b0.idata[k*FLITW +: FLITW] = pd[k];
      b0.ivalid[k]               = pv[k];
      b1.idata[k*FLITW +: FLITW] = qd[k];
      b1.ivalid[k]               = qv[k];
    end
  end
  assign b0.ivch   = 8'b11_10_01_00;
  assign b1.ivch   = 8'b11_10_01_00;
  assign b0.sel    = '0;
  assign b1.sel    = sel1;
  assign b0.oready = ordy0;
  assign b1.oready = 1'b1;

  pkt_mux_arb #(.NPORT(NPORT), .PAYW(PAYW), .TYPEW(TYPEW), .VCHW(VCHW), .MODE(0), .CNTW(CNTW))
    u_rr (.clk(clk), .rst(rst), .bus(b0));
  pkt_mux_arb #(.NPORT(NPORT), .PAYW(PAYW), .TYPEW(TYPEW), .VCHW(VCHW), .MODE(1), .CNTW(CNTW))
    u_sel (.clk(clk), .rst(rst), .bus(b1));

  logic [FLITW-1:0] out_q [$];
  always @(negedge clk)
    if (!rst && b0.ovalid && b0.oready) out_q.push_back(b0.odata);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLITW-1:0] fl(input logic [TYPEW-1:0] t, input logic [PAYW-1:0] pl);
    return {t, pl};
  endfunction

  function automatic logic [TYPEW-1:0] ftype(input int i, input int n);
    if (i == 0)     return TYPE_HEAD;
    if (i == n - 1) return TYPE_TAIL;
    return TYPE_DATA;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NPORT; k++) begin
      pv[k] = 1'b0; pd[k] = '0; qv[k] = 1'b0; qd[k] = '0;
    end
    ordy0 = 1'b1;
    sel1  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete();
  endtask

  // Presents an n-flit packet on port p of the round-robin instance.
  task automatic send_pkt(input int p, input int n, input logic [PAYW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int w;
      pd[p] = fl(ftype(i, n), base + PAYW'(i));
      pv[p] = 1'b1;
      for (w = 0; w < 200; w++) begin
        @(negedge clk);
        if (b0.iready[p]) break;
      end
      if (w == 200) chk("accept_timeout", 64'(p), 64'hFF);
      @(posedge clk); #1;
    end
    pv[p] = 1'b0;
  endtask

  task automatic send2(input int p);
    send_pkt(p, 2, PAYW'(p*16));
    send_pkt(p, 2, PAYW'(p*16 + 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int ord [8];
    do_reset();

    // reset state
    chk("rst_grant",  b0.grant, 0);
    chk("rst_ovalid", b0.ovalid, 0);
    chk("rst_odata",  b0.odata, 0);
    chk("rst_cnt",    b0.pkt_cnt, 0);
    chk("rst_err",    b0.err_stray, 0);

    // single packet on port 2
    pv[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pd[2] = fl(ftype(i, 5), PAYW'(16'h0200 + i));
      #1 chk("t1_iready", b0.iready, 4'b0100);
      @(posedge clk); #1;
      chk("t1_odata", b0.odata, fl(ftype(i, 5), PAYW'(16'h0200 + i)));
      if (i < 4) chk("t1_grant", b0.grant, 4'b0100);
    end
    pv[2] = 1'b0;
    chk("t1_ovch",  b0.ovch, 2);
    chk("t1_cnt",   b0.pkt_cnt, 1);
    chk("t1_idle",  b0.grant, 0);
    @(posedge clk); #1;
    chk("t1_ovalid_clr", b0.ovalid, 0);
    chk("t1_nflits", out_q.size(), 5);

    // reset mid-packet, then a fresh packet
    pv[0] = 1'b1; pd[0] = fl(TYPE_HEAD, 16'h0300);
    @(posedge clk); #1;
    pd[0] = fl(TYPE_DATA, 16'h0301);
    @(posedge clk); #1;
    pv[0] = 1'b0;
    chk("t6_grant_pre", b0.grant, 4'b0001);
    chk("t6_cnt_pre",   b0.pkt_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_grant_rst",  b0.grant, 0);
    chk("t6_ovalid_rst", b0.ovalid, 0);
    chk("t6_odata_rst",  b0.odata, 0);
    chk("t6_cnt_rst",    b0.pkt_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete();
    send_pkt(0, 3, 16'h0310);
    chk("t6_cnt_post", b0.pkt_cnt, 1);
    @(posedge clk); #1;
    chk("t6_nflits", out_q.size(), 3);
    for (int i = 0; i < 3 && i < out_q.size(); i++)
      chk("t6_flit", out_q[i], fl(ftype(i, 3), PAYW'(16'h0310 + i)));

    // four simultaneous HEADs, two rounds of 2-flit packets
    do_reset();
    t0 = cyc;
    fork
      send2(0);
      send2(1);
      send2(2);
      send2(3);
    join
    chk("t2_cycles", cyc - t0, 16);
    @(posedge clk); #1;
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("t2_nflits", out_q.size(), 16);
    for (int j = 0; j < 16 && j < out_q.size(); j++)
      chk("t2_flit", out_q[j],
          fl((j % 2 == 0) ? TYPE_HEAD : TYPE_TAIL, PAYW'(ord[j/2]*16 + (j/8)*4 + j%2)));
    chk("t2_cnt", b0.pkt_cnt, 8);

    // oready 1,0,0,1 during a packet on port 1
    do_reset();
    pv[1] = 1'b1; pd[1] = fl(TYPE_HEAD, 16'h0100);
    @(posedge clk); #1;
    pd[1] = fl(TYPE_DATA, 16'h0101); ordy0 = 1'b0;
    #1 chk("t3_stall_rdy0", b0.iready[1], 0);
    @(posedge clk); #1;
    chk("t3_hold0", b0.odata, fl(TYPE_HEAD, 16'h0100));
    #1 chk("t3_stall_rdy1", b0.iready[1], 0);
    @(posedge clk); #1;
    chk("t3_hold1", b0.odata, fl(TYPE_HEAD, 16'h0100));
    ordy0 = 1'b1;
    #1 chk("t3_resume_rdy", b0.iready[1], 1);
    @(posedge clk); #1;
    chk("t3_resume_data", b0.odata, fl(TYPE_DATA, 16'h0101));
    pd[1] = fl(TYPE_DATA, 16'h0102);
    @(posedge clk); #1;
    pd[1] = fl(TYPE_TAIL, 16'h0103);
    @(posedge clk); #1;
    pv[1] = 1'b0;
    @(posedge clk); #1;
    chk("t3_nflits", out_q.size(), 4);
    for (int i = 0; i < 4 && i < out_q.size(); i++)
      chk("t3_flit", out_q[i], fl(ftype(i, 4), PAYW'(16'h0100 + i)));

    // stray DATA on idle port 3
    do_reset();
    pv[3] = 1'b1; pd[3] = fl(TYPE_DATA, 16'h0333);
    #1 chk("t5_iready", b0.iready, 4'b1000);
    @(posedge clk); #1;
    pv[3] = 1'b0;
    chk("t5_err",    b0.err_stray, 1);
    chk("t5_ovalid", b0.ovalid, 0);
    @(posedge clk); #1;
    chk("t5_err_clr",  b0.err_stray, 0);
    chk("t5_ovalid2",  b0.ovalid, 0);
    chk("t5_grant",    b0.grant, 0);

    // external one-hot select
    do_reset();
    sel1 = 4'b0010;
    qv[0] = 1'b1; qd[0] = fl(TYPE_HEAD, 16'h1000);
    qv[1] = 1'b1; qd[1] = fl(TYPE_HEAD, 16'h1100);
    #1 chk("t4_iready", b1.iready, 4'b0010);
    @(posedge clk); #1;
    chk("t4_grant", b1.grant, 4'b0010);
    chk("t4_head",  b1.odata, fl(TYPE_HEAD, 16'h1100));
    qd[1] = fl(TYPE_DATA, 16'h1101); sel1 = 4'b0001;
    #1 chk("t4_locked_rdy", b1.iready, 4'b0010);
    @(posedge clk); #1;
    chk("t4_locked_grant", b1.grant, 4'b0010);
    chk("t4_data", b1.odata, fl(TYPE_DATA, 16'h1101));
    qd[1] = fl(TYPE_TAIL, 16'h1102);
    @(posedge clk); #1;
    qv[1] = 1'b0;
    chk("t4_tail",  b1.odata, fl(TYPE_TAIL, 16'h1102));
    chk("t4_idle",  b1.grant, 0);
    chk("t4_cnt1",  b1.pkt_cnt, 1);
    sel1 = 4'b0011;
    #1 chk("t4_multi_rdy", b1.iready, 0);
    @(posedge clk); #1;
    chk("t4_multi_grant",  b1.grant, 0);
    chk("t4_multi_ovalid", b1.ovalid, 0);
    sel1 = 4'b0001;
    #1 chk("t4_p0_rdy", b1.iready, 4'b0001);
    @(posedge clk); #1;
    chk("t4_p0_grant", b1.grant, 4'b0001);
    chk("t4_p0_head",  b1.odata, fl(TYPE_HEAD, 16'h1000));
    qd[0] = fl(TYPE_TAIL, 16'h1001);
    @(posedge clk); #1;
    qv[0] = 1'b0;
    chk("t4_cnt2", b1.pkt_cnt, 2);

    // packet counter wrap
    do_reset();
    for (int i = 0; i < 15; i++) send_pkt(0, 2, PAYW'(i*4));
    chk("t7_cnt15", b0.pkt_cnt, 15);
    send_pkt(0, 2, 16'h0500);
    chk("t7_wrap", b0.pkt_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
